// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the sized FIFO
// Purpose: ceil-log2 helper used for port/pointer widths and the bit
// positions of the sticky ERR flags.
package fifo_pkg;

  // Bit positions inside ERR[1:0].
  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;

  // ceil(log2(n)); clog2(1) = 0, clog2(5) = 3.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - body storage for the sized FIFO (entries 1..depth-1)
// Purpose: simple register-file storage, one synchronous write port and one
// asynchronous read port, no reset (contents are don't-care until written).
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, combinational from raddr
module fifo_ram #(
  parameter int width   = 1,
  parameter int entries = 3,
  parameter int aw      = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [entries];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sized_fifo_lvl.sv
// rtl/sized_fifo_lvl.sv - depth-parametrised FIFO with registered head, count and level flags
// Purpose: synchronous FIFO keeping entry 0 in a head register (D_OUT) and
// entries 1..depth-1 in a circular fifo_ram. COUNT and all flags are
// registered from the next-state count, so no ENQ/DEQ -> output comb path.
// Ports:
//   CLK, RST          clock; asynchronous active-high reset
//   CLR               synchronous clear, overrides ENQ/DEQ
//   D_IN, ENQ, DEQ    enqueue data/strobe, dequeue strobe
//   D_OUT             head entry, valid while EMPTY_N=1
//   FULL_N, EMPTY_N   free-entry / valid-entry flags
//   COUNT             occupancy 0..depth
//   ALMOST_FULL_N     0 when COUNT >= af_thresh
//   ALMOST_EMPTY_N    0 when COUNT <= ae_thresh
//   ERR               sticky {enq_overflow, deq_underflow}
module sized_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int   width     = 1,
  parameter int   depth     = 4,
  parameter logic guarded   = 1'b1,
  parameter int   af_thresh = depth - 1,
  parameter int   ae_thresh = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLR,
  input  logic [width-1:0]          D_IN,
  input  logic                      ENQ,
  input  logic                      DEQ,
  output logic [width-1:0]          D_OUT,
  output logic                      FULL_N,
  output logic                      EMPTY_N,
  output logic [clog2(depth+1)-1:0] COUNT,
  output logic                      ALMOST_FULL_N,
  output logic                      ALMOST_EMPTY_N,
  output logic [1:0]                ERR
);

  localparam int CW     = clog2(depth + 1);
  localparam int AW_RAW = clog2(depth - 1);
  // depth=2 leaves a single body slot; keep at least one address bit.
  localparam int AW     = (AW_RAW < 1) ? 1 : AW_RAW;

  localparam logic [CW-1:0] DEPTH_C  = CW'(depth);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] AF_C     = CW'(af_thresh);
  localparam logic [CW-1:0] AE_C     = CW'(ae_thresh);
  localparam logic [AW-1:0] PTR_LAST = AW'(depth - 2);

  // Body pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [width-1:0] head_q, head_d;
  logic [1:0]       err_q, err_d;
  logic             empty_n_q, empty_n_d;
  logic             full_n_q, full_n_d;
  logic             almost_full_n_q, almost_full_n_d;
  logic             almost_empty_n_q, almost_empty_n_d;

  logic             ram_we;
  logic [width-1:0] ram_rdata;

  logic is_empty;
  logic is_full;
  logic deq_ok;
  logic enq_ok;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  assign deq_ok   = DEQ && !is_empty;
  // When full, an ENQ only lands if the same-cycle DEQ frees a slot and the
  // part is unguarded.
  assign enq_ok   = ENQ && (!is_full || (DEQ && !guarded));

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    err_d    = err_q;
    ram_we   = 1'b0;

    if (CLR) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      err_d    = '0;
    end else begin
      if (ENQ && !enq_ok) begin
        err_d[ERR_OVERFLOW] = 1'b1;
      end
      if (DEQ && is_empty) begin
        err_d[ERR_UNDERFLOW] = 1'b1;
      end

      unique case ({enq_ok, deq_ok})
        2'b10: begin
          if (is_empty) begin
            head_d = D_IN;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
          end
          count_d = count_q + ONE_C;
        end
        2'b01: begin
          if (count_q != ONE_C) begin
            head_d   = ram_rdata;
            rd_ptr_d = ptr_inc(rd_ptr_q);
          end
          count_d = count_q - ONE_C;
        end
        2'b11: begin
          if (count_q == ONE_C) begin
            // Body is empty: the new entry becomes the head directly.
            head_d = D_IN;
          end else begin
            // Async read sees the old slot even when wr_ptr == rd_ptr (full).
            head_d   = ram_rdata;
            rd_ptr_d = ptr_inc(rd_ptr_q);
            ram_we   = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
          end
        end
        default: begin
        end
      endcase
    end

    empty_n_d        = (count_d != '0);
    full_n_d         = (count_d != DEPTH_C);
    almost_full_n_d  = (count_d < AF_C);
    almost_empty_n_d = (count_d > AE_C);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q          <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      err_q            <= '0;
      empty_n_q        <= 1'b0;
      full_n_q         <= 1'b1;
      almost_full_n_q  <= 1'b1;
      almost_empty_n_q <= 1'b0;
    end else begin
      count_q          <= count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      err_q            <= err_d;
      empty_n_q        <= empty_n_d;
      full_n_q         <= full_n_d;
      almost_full_n_q  <= almost_full_n_d;
      almost_empty_n_q <= almost_empty_n_d;
    end
  end

  // Head is data storage, intentionally not reset.
  always_ff @(posedge CLK) begin
    head_q <= head_d;
  end

  fifo_ram #(
    .width   (width),
    .entries (depth - 1),
    .aw      (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (D_IN),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign D_OUT          = head_q;
  assign COUNT          = count_q;
  assign EMPTY_N        = empty_n_q;
  assign FULL_N         = full_n_q;
  assign ALMOST_FULL_N  = almost_full_n_q;
  assign ALMOST_EMPTY_N = almost_empty_n_q;
  assign ERR            = err_q;

endmodule

// File: tb/tb_sized_fifo_lvl.sv
// tb/tb_sized_fifo_lvl.sv - self-checking bench for sized_fifo_lvl
module tb_sized_fifo_lvl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // a: depth 4, guarded, af=3, ae=1
  logic       a_clr, a_enq, a_deq;
  logic [7:0] a_din, a_dout;
  logic       a_full_n, a_empty_n, a_af_n, a_ae_n;
  logic [2:0] a_count;
  logic [1:0] a_err;
  // b: depth 4, unguarded
  logic       b_clr, b_enq, b_deq;
  logic [7:0] b_din, b_dout;
  logic       b_full_n, b_empty_n, b_af_n, b_ae_n;
  logic [2:0] b_count;
  logic [1:0] b_err;
  // c: depth 5, guarded, default thresholds (af=4, ae=1)
  logic       c_clr, c_enq, c_deq;
  logic [7:0] c_din, c_dout;
  logic       c_full_n, c_empty_n, c_af_n, c_ae_n;
  logic [2:0] c_count;
  logic [1:0] c_err;

  sized_fifo_lvl #(.width(8), .depth(4), .guarded(1'b1), .af_thresh(3), .ae_thresh(1)) dut_a (
    .CLK(clk), .RST(rst), .CLR(a_clr), .D_IN(a_din), .ENQ(a_enq), .DEQ(a_deq),
    .D_OUT(a_dout), .FULL_N(a_full_n), .EMPTY_N(a_empty_n), .COUNT(a_count),
    .ALMOST_FULL_N(a_af_n), .ALMOST_EMPTY_N(a_ae_n), .ERR(a_err)
  );

  sized_fifo_lvl #(.width(8), .depth(4), .guarded(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .CLR(b_clr), .D_IN(b_din), .ENQ(b_enq), .DEQ(b_deq),
    .D_OUT(b_dout), .FULL_N(b_full_n), .EMPTY_N(b_empty_n), .COUNT(b_count),
    .ALMOST_FULL_N(b_af_n), .ALMOST_EMPTY_N(b_ae_n), .ERR(b_err)
  );

  sized_fifo_lvl #(.width(8), .depth(5), .guarded(1'b1)) dut_c (
    .CLK(clk), .RST(rst), .CLR(c_clr), .D_IN(c_din), .ENQ(c_enq), .DEQ(c_deq),
    .D_OUT(c_dout), .FULL_N(c_full_n), .EMPTY_N(c_empty_n), .COUNT(c_count),
    .ALMOST_FULL_N(c_af_n), .ALMOST_EMPTY_N(c_ae_n), .ERR(c_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  vals [4];
  logic [7:0]  cq [$];
  logic [1:0]  c_merr;
  logic        m_dq, m_eq;
  logic [31:0] r;

  initial begin
    rst = 1'b1;
    a_clr = 0; a_enq = 0; a_deq = 0; a_din = 0;
    b_clr = 0; b_enq = 0; b_deq = 0; b_din = 0;
    c_clr = 0; c_enq = 0; c_deq = 0; c_din = 0;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // reset state
    chk("rst_count", a_count, 0);
    chk("rst_empty_n", a_empty_n, 0);
    chk("rst_full_n", a_full_n, 1);
    chk("rst_ae_n", a_ae_n, 0);
    chk("rst_af_n", a_af_n, 1);
    chk("rst_err", a_err, 0);
    chk("rst_c_count", c_count, 0);

    // 1: async reset mid-traffic, with an error flag already set
    a_deq = 1; cyc(); a_deq = 0;
    chk("t1_underflow_err", a_err, 2'b01);
    chk("t1_underflow_count", a_count, 0);
    a_enq = 1; a_din = 8'hA1; cyc(); a_din = 8'hA2; cyc(); a_enq = 0;
    chk("t1_pre_rst_count", a_count, 2);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_count", a_count, 0);
    chk("t1_async_empty_n", a_empty_n, 0);
    chk("t1_async_full_n", a_full_n, 1);
    chk("t1_async_ae_n", a_ae_n, 0);
    chk("t1_async_af_n", a_af_n, 1);
    chk("t1_async_err", a_err, 0);
    rst = 1'b0;
    cyc();

    // 2: fill and drain in order
    a_enq = 1;
    for (int i = 0; i < 4; i++) begin
      a_din = vals[i];
      cyc();
      chk("t2_fill_count", a_count, i + 1);
      chk("t2_fill_head", a_dout, 8'h11);
      chk("t2_fill_af_n", a_af_n, (i + 1) < 3);
      chk("t2_fill_ae_n", a_ae_n, (i + 1) > 1);
    end
    a_enq = 0;
    chk("t2_full_n", a_full_n, 0);
    chk("t2_empty_n", a_empty_n, 1);
    a_deq = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", a_dout, vals[i]);
      cyc();
      chk("t2_drain_count", a_count, 3 - i);
    end
    a_deq = 0;
    chk("t2_drained_empty_n", a_empty_n, 0);
    chk("t2_drained_err", a_err, 0);

    // 3: ENQ+DEQ while full, guarded vs unguarded
    a_enq = 1;
    for (int i = 0; i < 4; i++) begin a_din = vals[i]; cyc(); end
    a_enq = 0;
    chk("t3a_full_count", a_count, 4);
    a_enq = 1; a_deq = 1; a_din = 8'h55; cyc(); a_enq = 0; a_deq = 0;
    chk("t3a_count", a_count, 3);
    chk("t3a_err", a_err, 2'b10);
    chk("t3a_head", a_dout, 8'h22);
    a_deq = 1;
    for (int i = 1; i < 4; i++) begin
      chk("t3a_order", a_dout, vals[i]);
      cyc();
    end
    a_deq = 0;
    chk("t3a_drain_count", a_count, 0);
    chk("t3a_drain_err", a_err, 2'b10);

    b_enq = 1;
    for (int i = 0; i < 4; i++) begin b_din = vals[i]; cyc(); end
    b_enq = 1; b_deq = 1; b_din = 8'h55; cyc(); b_enq = 0; b_deq = 0;
    chk("t3b_count", b_count, 4);
    chk("t3b_err", b_err, 0);
    chk("t3b_full_n", b_full_n, 0);
    b_deq = 1;
    chk("t3b_order0", b_dout, 8'h22); cyc();
    chk("t3b_order1", b_dout, 8'h33); cyc();
    chk("t3b_order2", b_dout, 8'h44); cyc();
    chk("t3b_order3", b_dout, 8'h55); cyc();
    b_deq = 0;
    chk("t3b_drain_count", b_count, 0);

    // 4: underflow, then ENQ+DEQ on empty
    a_clr = 1; cyc(); a_clr = 0;
    chk("t4_clr_err", a_err, 0);
    a_deq = 1; cyc();
    chk("t4_uf_err", a_err, 2'b01);
    chk("t4_uf_count", a_count, 0);
    a_enq = 1; a_din = 8'h66; cyc(); a_enq = 0; a_deq = 0;
    chk("t4_ed_count", a_count, 1);
    chk("t4_ed_head", a_dout, 8'h66);
    chk("t4_ed_empty_n", a_empty_n, 1);
    chk("t4_ed_err", a_err, 2'b01);

    // 6: almost-full threshold and CLR overriding ENQ
    a_enq = 1; a_din = 8'h77; cyc();
    chk("t6_c2_count", a_count, 2);
    chk("t6_c2_af_n", a_af_n, 1);
    a_din = 8'h88; cyc();
    chk("t6_c3_count", a_count, 3);
    chk("t6_c3_af_n", a_af_n, 0);
    chk("t6_c3_full_n", a_full_n, 1);
    a_clr = 1; a_din = 8'h5A; cyc(); a_clr = 0; a_enq = 0;
    chk("t6_clr_count", a_count, 0);
    chk("t6_clr_af_n", a_af_n, 1);
    chk("t6_clr_ae_n", a_ae_n, 0);
    chk("t6_clr_empty_n", a_empty_n, 0);
    chk("t6_clr_err", a_err, 0);
    a_enq = 1; a_din = 8'h99; cyc(); a_din = 8'hAA; cyc(); a_enq = 0;
    chk("t6_post_head", a_dout, 8'h99);
    a_deq = 1; cyc(); a_deq = 0;
    chk("t6_post_next", a_dout, 8'hAA);
    chk("t6_post_count", a_count, 1);

    // 5: randomized traffic on depth 5 against a queue model
    c_merr = 2'b00;
    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      if (((i / 25) % 2) == 0) begin
        c_enq = (r[1:0] != 2'b00);
        c_deq = (r[3:2] == 2'b00);
      end else begin
        c_enq = (r[1:0] == 2'b00);
        c_deq = (r[3:2] != 2'b00);
      end
      c_clr = (r[9:4] == 6'd0);
      c_din = r[23:16];
      if (c_clr) begin
        cq.delete();
        c_merr = 2'b00;
      end else begin
        if (c_enq && cq.size() == 5) c_merr[1] = 1'b1;
        if (c_deq && cq.size() == 0) c_merr[0] = 1'b1;
        m_dq = c_deq && (cq.size() > 0);
        m_eq = c_enq && (cq.size() < 5);
        if (m_dq) void'(cq.pop_front());
        if (m_eq) cq.push_back(c_din);
      end
      cyc();
      chk("t5_count", c_count, cq.size());
      chk("t5_empty_n", c_empty_n, cq.size() != 0);
      chk("t5_full_n", c_full_n, cq.size() != 5);
      chk("t5_af_n", c_af_n, cq.size() < 4);
      chk("t5_ae_n", c_ae_n, cq.size() > 1);
      chk("t5_err", c_err, c_merr);
      if (cq.size() > 0) chk("t5_head", c_dout, cq[0]);
    end
    c_enq = 0; c_deq = 0; c_clr = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
